// File: rtl/complex_count_checker.sv
// Receive-side monitor for a binary/Gray count stream: decodes each valid word,
// checks it is the modulo-2^WIDTH successor of the last one, and tracks lock/errors.
module complex_count_checker #(
    parameter int WIDTH    = 3,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             VALID,
    input  logic             M,
    input  logic [WIDTH-1:0] CODE,
    output logic [WIDTH-1:0] BIN,
    output logic             LOCKED,
    output logic             ERROR,
    output logic [ERR_W-1:0] ERR_COUNT
);

    localparam int MC_W = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        LKD   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             m_q, m_d;
    logic             locked_q, locked_d;
    logic             error_q, error_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic [WIDTH-1:0] dec;
    logic             good;
    logic             mchg;

    // Reflected-Gray decode walks from the MSB down, so dec[i+1] is already final.
    always_comb begin
        dec = CODE;
        if (M) begin
            for (int i = WIDTH - 2; i >= 0; i--) begin
                dec[i] = dec[i+1] ^ CODE[i];
            end
        end
    end

    // bin_q doubles as the previous sample; the +1 wraps naturally at WIDTH bits.
    assign good = (dec == bin_q + WIDTH'(1));
    assign mchg = (state_q != IDLE) && (M != m_q);

    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        bin_d       = bin_q;
        m_d         = m_q;
        locked_d    = locked_q;
        error_d     = 1'b0;
        err_count_d = err_count_q;

        if (VALID) begin
            bin_d = dec;
            m_d   = M;
            unique case (state_q)
                IDLE: begin
                    state_d     = TRACK;
                    match_cnt_d = '0;
                end
                TRACK: begin
                    if (mchg || !good) begin
                        match_cnt_d = '0;
                    end else begin
                        match_cnt_d = match_cnt_q + MC_W'(1);
                        if (match_cnt_q + MC_W'(1) == MC_W'(LOCK_CNT)) begin
                            state_d  = LKD;
                            locked_d = 1'b1;
                        end
                    end
                end
                LKD: begin
                    if (mchg) begin
                        // A deliberate encoding switch is a resync, not a fault.
                        state_d     = TRACK;
                        locked_d    = 1'b0;
                        match_cnt_d = '0;
                    end else if (!good) begin
                        state_d     = TRACK;
                        locked_d    = 1'b0;
                        match_cnt_d = '0;
                        error_d     = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + ERR_W'(1);
                        end
                    end
                end
                default: begin
                    state_d     = IDLE;
                    match_cnt_d = '0;
                end
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so every register samples
    // the pre-edge values computed above; updates happen on the falling edge.
    always_ff @(negedge CLOCK) begin
        if (RESET) begin
            state_q     <= IDLE;
            match_cnt_q <= '0;
            bin_q       <= '0;
            m_q         <= 1'b0;
            locked_q    <= 1'b0;
            error_q     <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            bin_q       <= bin_d;
            m_q         <= m_d;
            locked_q    <= locked_d;
            error_q     <= error_d;
            err_count_q <= err_count_d;
        end
    end

    assign BIN       = bin_q;
    assign LOCKED    = locked_q;
    assign ERROR     = error_q;
    assign ERR_COUNT = err_count_q;

endmodule

// File: tb/tb_complex_count_checker.sv
// Directed self-checking bench for complex_count_checker; a second instance with
// ERR_W=2 shares the stimulus to exercise ERR_COUNT saturation.
module tb_complex_count_checker;

    logic       clk;
    logic       RESET;
    logic       VALID;
    logic       M;
    logic [2:0] CODE;

    logic [2:0] bin_a,    bin_b;
    logic       locked_a, locked_b;
    logic       error_a,  error_b;
    logic [7:0] errc_a;
    logic [1:0] errc_b;

    int total = 0;
    int bad   = 0;

    complex_count_checker #(.WIDTH(3), .LOCK_CNT(4), .ERR_W(8)) dut (
        .CLOCK(clk), .RESET(RESET), .VALID(VALID), .M(M), .CODE(CODE),
        .BIN(bin_a), .LOCKED(locked_a), .ERROR(error_a), .ERR_COUNT(errc_a)
    );

    complex_count_checker #(.WIDTH(3), .LOCK_CNT(4), .ERR_W(2)) dut_w2 (
        .CLOCK(clk), .RESET(RESET), .VALID(VALID), .M(M), .CODE(CODE),
        .BIN(bin_b), .LOCKED(locked_b), .ERROR(error_b), .ERR_COUNT(errc_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive on the rising edge, let the DUT sample on the falling edge, then check.
    task automatic step(input string tag, input logic rst, input logic v, input logic m,
                        input logic [2:0] code, input int eb, input int el, input int ee,
                        input int ec);
        int ec2;
        @(posedge clk);
        RESET = rst;
        VALID = v;
        M     = m;
        CODE  = code;
        @(negedge clk);
        #1;
        ec2 = (ec > 3) ? 3 : ec;
        check({tag, ".bin"},     32'(bin_a),    32'(eb));
        check({tag, ".locked"},  32'(locked_a), 32'(el));
        check({tag, ".error"},   32'(error_a),  32'(ee));
        check({tag, ".errcnt"},  32'(errc_a),   32'(ec));
        check({tag, ".w2bin"},   32'(bin_b),    32'(eb));
        check({tag, ".w2errcnt"},32'(errc_b),   32'(ec2));
    endtask

    initial begin
        int cur;
        RESET = 1'b1;
        VALID = 1'b0;
        M     = 1'b0;
        CODE  = 3'd0;

        // 1: reset, then binary 0..7,0,1; lock at the 5th word; wrap is legal
        step("rst", 1, 0, 0, 3'd3, 0, 0, 0, 0);
        step("rst2", 1, 1, 0, 3'd5, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step("t1", 0, 1, 0, 3'(i % 8), i % 8, (i >= 4) ? 1 : 0, 0, 0);
        end

        // 2: Gray stream; the encoding switch restarts the lock count
        step("t2.s1", 0, 1, 1, 3'b000, 0, 0, 0, 0);
        step("t2.s2", 0, 1, 1, 3'b001, 1, 0, 0, 0);
        step("t2.s3", 0, 1, 1, 3'b011, 2, 0, 0, 0);
        step("t2.s4", 0, 1, 1, 3'b010, 3, 0, 0, 0);
        step("t2.s5", 0, 1, 1, 3'b110, 4, 1, 0, 0);
        step("t2.s6", 0, 1, 1, 3'b111, 5, 1, 0, 0);
        step("t2.s7", 0, 1, 1, 3'b101, 6, 1, 0, 0);
        step("t2.s8", 0, 1, 1, 3'b100, 7, 1, 0, 0);
        step("t2.s9", 0, 1, 1, 3'b000, 0, 1, 0, 0);

        // 3: relock in binary, then a skip 3->5 while locked
        step("t3.p5", 0, 1, 0, 3'd5, 5, 0, 0, 0);
        step("t3.p6", 0, 1, 0, 3'd6, 6, 0, 0, 0);
        step("t3.p7", 0, 1, 0, 3'd7, 7, 0, 0, 0);
        step("t3.p0", 0, 1, 0, 3'd0, 0, 0, 0, 0);
        step("t3.p1", 0, 1, 0, 3'd1, 1, 1, 0, 0);
        step("t3.s2", 0, 1, 0, 3'd2, 2, 1, 0, 0);
        step("t3.s3", 0, 1, 0, 3'd3, 3, 1, 0, 0);
        step("t3.s5", 0, 1, 0, 3'd5, 5, 0, 1, 1);
        step("t3.s6", 0, 1, 0, 3'd6, 6, 0, 0, 1);
        step("t3.s7", 0, 1, 0, 3'd7, 7, 0, 0, 1);
        step("t3.s0", 0, 1, 0, 3'd0, 0, 0, 0, 1);
        step("t3.s1", 0, 1, 0, 3'd1, 1, 1, 0, 1);

        // 4: gaps of 1..3 idle cycles; junk CODE during gaps must be ignored
        step("t4.s2", 0, 1, 0, 3'd2, 2, 1, 0, 1);
        step("t4.g1", 0, 0, 0, 3'd7, 2, 1, 0, 1);
        step("t4.s3", 0, 1, 0, 3'd3, 3, 1, 0, 1);
        step("t4.g2a", 0, 0, 1, 3'd0, 3, 1, 0, 1);
        step("t4.g2b", 0, 0, 0, 3'd6, 3, 1, 0, 1);
        step("t4.s4", 0, 1, 0, 3'd4, 4, 1, 0, 1);
        step("t4.g3a", 0, 0, 0, 3'd1, 4, 1, 0, 1);
        step("t4.g3b", 0, 0, 0, 3'd4, 4, 1, 0, 1);
        step("t4.g3c", 0, 0, 0, 3'd2, 4, 1, 0, 1);
        step("t4.s5", 0, 1, 0, 3'd5, 5, 1, 0, 1);

        // 5: switch to Gray continuation 6,7,0,1,2 -> drop lock, no error, relock
        step("t5.g6", 0, 1, 1, 3'b101, 6, 0, 0, 1);
        step("t5.g7", 0, 1, 1, 3'b100, 7, 0, 0, 1);
        step("t5.g0", 0, 1, 1, 3'b000, 0, 0, 0, 1);
        step("t5.g1", 0, 1, 1, 3'b001, 1, 0, 0, 1);
        step("t5.g2", 0, 1, 1, 3'b011, 2, 1, 0, 1);

        // 6: from reset, five locked stalls; ERR_W=2 instance saturates at 3
        step("t6.rst", 1, 0, 0, 3'd0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step("t6.lock", 0, 1, 0, 3'(i), i, (i == 4) ? 1 : 0, 0, 0);
        end
        cur = 4;
        for (int k = 0; k < 5; k++) begin
            step("t6.stall", 0, 1, 0, 3'(cur), cur, 0, 1, k + 1);
            step("t6.idle",  0, 0, 0, 3'(cur), cur, 0, 0, k + 1);
            for (int j = 1; j <= 4; j++) begin
                step("t6.relock", 0, 1, 0, 3'((cur + j) % 8), (cur + j) % 8,
                     (j == 4) ? 1 : 0, 0, k + 1);
            end
            cur = (cur + 4) % 8;
        end
        // Reset wins over a simultaneous locked break
        step("t6.rstbrk", 1, 1, 0, 3'(cur + 3), 0, 0, 0, 0);
        // First sample after reset is unchecked even though 5 != 0+1
        step("t6.idle5", 0, 1, 0, 3'd5, 5, 0, 0, 0);
        step("t6.r6", 0, 1, 0, 3'd6, 6, 0, 0, 0);
        step("t6.r7", 0, 1, 0, 3'd7, 7, 0, 0, 0);
        step("t6.r0", 0, 1, 0, 3'd0, 0, 0, 0, 0);
        step("t6.r1", 0, 1, 0, 3'd1, 1, 1, 0, 0);
        check("t6.w2locked", 32'(locked_b), 32'd1);
        check("t6.w2error",  32'(error_b),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
